// File: rtl/kernel_bc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// kernel_bc_ctrl_pkg
// Definitions shared by the kernel_bc stage controllers:
//   ctrl_state_e      FSM encoding (ST_IDLE / ST_ISSUE / ST_DRAIN / ST_DONE)
//   AP_READY_PULSE_W  width in cycles of the ap_ready pulse
//   AP_DONE_PULSE_W   width in cycles of the ap_done pulse
// ----------------------------------------------------------------------------
package kernel_bc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  localparam int unsigned AP_READY_PULSE_W = 32'd1;
  localparam int unsigned AP_DONE_PULSE_W  = 32'd1;

endpackage : kernel_bc_ctrl_pkg

// File: rtl/kernel_bc_inflight_cnt.sv
// ----------------------------------------------------------------------------
// kernel_bc_inflight_cnt
// Saturating up/down counter of start tokens written but not yet completed.
// A decrement at zero is rejected and reported on o_underflow.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   inc          token written this cycle
//   dec          iteration completed this cycle
//   cnt          current count
//   underflow    combinational: dec requested while cnt==0
// ----------------------------------------------------------------------------
module kernel_bc_inflight_cnt #(
  parameter int unsigned W   = 32'd3,
  parameter int unsigned MAX = 32'd4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         underflow
);

  logic [W-1:0] r_cnt;
  logic         w_zero;
  logic         w_full;

  assign w_zero    = (r_cnt == W'(0));
  assign w_full    = (r_cnt == W'(MAX));
  assign underflow = dec & w_zero;
  assign cnt       = r_cnt;

  // Count update; a simultaneous inc/dec cancels unless the dec is rejected at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= W'(0);
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (!w_full) r_cnt <= r_cnt + W'(1);
        end
        2'b01: begin
          if (!w_zero) r_cnt <= r_cnt - W'(1);
        end
        2'b11: begin
          if (w_zero) r_cnt <= r_cnt + W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule : kernel_bc_inflight_cnt

// File: rtl/kernel_bc_write_back_start_ctrl.sv
// ----------------------------------------------------------------------------
// kernel_bc_write_back_start_ctrl
// Issues one start token per iteration into the write_back start FIFO, keeping
// at most MAX_INFLIGHT iterations outstanding, and produces the
// ap_ready/ap_done/ap_idle handshake for the enclosing dataflow region.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ap_start        host start (sampled only in IDLE), num_iter latched with it
//   ap_ready        1-cycle pulse after the final token is written
//   ap_done         1-cycle pulse once all iterations completed
//   ap_idle         high while IDLE
//   tok_full_n      start FIFO not-full
//   tok_write       start FIFO write strobe (combinational in tok_full_n)
//   tok_din         start FIFO data, 1 on the final token of the run
//   tail_done       per-iteration completion pulse from write_back
//   inflight        outstanding token count
//   err_underflow   sticky: completion seen with nothing outstanding
// ----------------------------------------------------------------------------
module kernel_bc_write_back_start_ctrl
  import kernel_bc_ctrl_pkg::*;
#(
  parameter int unsigned ITER_W       = 32'd32,
  parameter int unsigned MAX_INFLIGHT = 32'd4,
  parameter int unsigned INF_W        = 32'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ap_start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic              tok_full_n,
  output logic              tok_write,
  output logic              tok_din,
  input  logic              tail_done,
  output logic [INF_W-1:0]  inflight,
  output logic              err_underflow
);

  ctrl_state_e       r_state;
  logic [ITER_W-1:0] r_n_lat;
  logic [ITER_W-1:0] r_issued;
  logic [ITER_W-1:0] r_done_cnt;
  logic              r_ap_ready;
  logic              r_ap_done;
  logic              r_err;

  logic [INF_W-1:0]  w_inflight;
  logic              w_underflow;
  logic              w_tail_acc;
  logic              w_last;
  logic              w_tok_write;

  kernel_bc_inflight_cnt #(
    .W   (INF_W),
    .MAX (MAX_INFLIGHT)
  ) u_inflight (
    .clk       (clk),
    .reset     (reset),
    .inc       (w_tok_write),
    .dec       (tail_done),
    .cnt       (w_inflight),
    .underflow (w_underflow)
  );

  // A completion only counts when something was outstanding.
  assign w_tail_acc = tail_done & ~w_underflow;

  // Issue-side decode; n_lat is never 0 in ISSUE, so n_lat-1 cannot wrap there.
  always_comb begin
    w_last      = 1'b0;
    w_tok_write = 1'b0;
    if (r_state == ST_ISSUE) begin
      w_last      = (r_issued == (r_n_lat - ITER_W'(1)));
      w_tok_write = (w_inflight < INF_W'(MAX_INFLIGHT)) & tok_full_n;
    end else begin
      w_last      = 1'b0;
      w_tok_write = 1'b0;
    end
  end

  // Control FSM with issue/complete counters and registered handshake pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_n_lat    <= ITER_W'(0);
      r_issued   <= ITER_W'(0);
      r_done_cnt <= ITER_W'(0);
      r_ap_ready <= 1'b0;
      r_ap_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ap_ready <= 1'b0;
      r_ap_done  <= 1'b0;
      if (w_underflow) r_err <= 1'b1;
      if (w_tail_acc) r_done_cnt <= r_done_cnt + ITER_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_n_lat    <= num_iter;
            r_issued   <= ITER_W'(0);
            r_done_cnt <= ITER_W'(0);
            if (num_iter == ITER_W'(0)) begin
              // Empty run: ready and done pulse together in DONE.
              r_ap_ready <= 1'b1;
              r_ap_done  <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_tok_write) begin
            r_issued <= r_issued + ITER_W'(1);
            if (w_last) begin
              r_ap_ready <= 1'b1;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_done_cnt == r_n_lat) begin
            r_ap_done <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ap_ready      = r_ap_ready;
  assign ap_done       = r_ap_done;
  assign ap_idle       = (r_state == ST_IDLE);
  assign tok_write     = w_tok_write;
  assign tok_din       = w_last;
  assign inflight      = w_inflight;
  assign err_underflow = r_err;

endmodule : kernel_bc_write_back_start_ctrl

// File: tb/tb_kernel_bc_write_back_start_ctrl.sv
// Scoreboard bench for kernel_bc_write_back_start_ctrl. Expected token values and
// handshake events are queued when a run is started; a negedge monitor pops and
// compares them when the DUT presents writes / ap_ready / ap_done. A simple
// outstanding-token count model checks inflight and err_underflow every cycle.
module tb_kernel_bc_write_back_start_ctrl;

  localparam int ITER_W = 32;
  localparam int MAXI   = 4;
  localparam int INF_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ap_start;
  logic [ITER_W-1:0] num_iter;
  logic              ap_ready, ap_done, ap_idle;
  logic              tok_full_n = 1'b1;
  logic              tok_write, tok_din;
  logic              tail_done = 1'b0;
  logic [INF_W-1:0]  inflight;
  logic              err_underflow;

  always #5 clk = ~clk;

  kernel_bc_write_back_start_ctrl #(
    .ITER_W(ITER_W), .MAX_INFLIGHT(MAXI), .INF_W(INF_W)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .num_iter(num_iter),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .tok_full_n(tok_full_n), .tok_write(tok_write), .tok_din(tok_din),
    .tail_done(tail_done), .inflight(inflight), .err_underflow(err_underflow)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // environment knobs
  int full_mode   = 0;   // 0: always not-full, 1: toggle, 2: random
  int tail_budget = -1;  // -1 unlimited, 0 hold, >0 that many completions
  int tail_min    = 3;
  int tail_max    = 3;
  int force_tail  = 0;
  int tail_due[$];

  // scoreboard and model
  bit exp_din[$];
  int exp_ready[$];
  int exp_done[$];
  int start_cyc, last_wr_cyc, last_acc_cyc;
  int run_wr, run_acc;
  int mdl_out = 0;
  bit mdl_err = 1'b0;
  int coincide2 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO back-pressure and write_back completion responder
  always begin
    @(posedge clk); #1;
    if (reset) begin
      tail_due.delete();
      tail_done  = 1'b0;
      tok_full_n = 1'b1;
    end else begin
      case (full_mode)
        0:       tok_full_n = 1'b1;
        1:       tok_full_n = ~tok_full_n;
        default: tok_full_n = 1'($urandom_range(0, 1));
      endcase
      if (force_tail > 0) begin
        tail_done = 1'b1;
        force_tail--;
      end else if (tail_budget != 0 && tail_due.size() > 0 && tail_due[0] <= cyc) begin
        tail_done = 1'b1;
        void'(tail_due.pop_front());
        if (tail_budget > 0) tail_budget--;
      end else begin
        tail_done = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    bit d;
    int n;
    int nxt;
    if (reset) begin
      exp_din.delete();
      exp_ready.delete();
      exp_done.delete();
      mdl_out = 0;
      mdl_err = 1'b0;
    end else begin
      chk("inflight", inflight, mdl_out);
      chk("err_underflow", err_underflow, mdl_err);
      if (tok_write) begin
        chk("wr_while_full", tok_full_n, 1);
        chk("wr_over_limit", mdl_out < MAXI, 1);
        chk("write_expected", exp_din.size() > 0, 1);
        if (exp_din.size() > 0) begin
          d = exp_din.pop_front();
          chk("tok_din", tok_din, d);
          if (run_wr == 0 && full_mode == 0) chk("first_write_latency", cyc - start_cyc, 1);
          run_wr++;
          if (d) last_wr_cyc = cyc;
        end
        tail_due.push_back(cyc + int'($urandom_range(tail_min, tail_max)));
      end
      if (tail_done && mdl_out > 0) begin
        run_acc++;
        last_acc_cyc = cyc;
      end
      if (ap_ready) begin
        chk("ready_expected", exp_ready.size() > 0, 1);
        if (exp_ready.size() > 0) begin
          n = exp_ready.pop_front();
          if (n == 0) begin
            chk("ready_zero_latency", cyc - start_cyc, 1);
            chk("ready_zero_with_done", ap_done, 1);
          end else begin
            chk("ready_after_last_write", cyc - last_wr_cyc, 1);
            chk("ready_all_written", run_wr, n);
          end
        end
      end
      if (ap_done) begin
        chk("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          n = exp_done.pop_front();
          chk("done_completions", run_acc, n);
          chk("done_writes", run_wr, n);
          chk("done_inflight", mdl_out, 0);
          if (n > 0) chk("done_after_last_tail", (cyc - last_acc_cyc) inside {[1:2]}, 1);
        end
      end
      if (tok_write && tail_done && mdl_out == 2) coincide2++;
      // model update: writes add, completions remove only what is outstanding
      nxt = mdl_out + (tok_write ? 1 : 0);
      if (tail_done) begin
        if (mdl_out > 0) nxt = nxt - 1;
        else mdl_err = 1'b1;
      end
      mdl_out = nxt;
    end
  end

  task automatic start_run(input int n);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!ap_idle && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_before_start", ap_idle, 1);
    for (int i = 0; i < n; i++) exp_din.push_back(i == n - 1);
    exp_ready.push_back(n);
    exp_done.push_back(n);
    run_wr    = 0;
    run_acc   = 0;
    start_cyc = cyc;
    ap_start  = 1'b1;
    num_iter  = ITER_W'(n);
    @(posedge clk); #1;
    ap_start = 1'b0;
    num_iter = $urandom;
    @(negedge clk);
    chk("busy_after_start", ap_idle, 0);
  endtask

  task automatic wait_run_end(input int limit);
    int t;
    t = 0;
    while (exp_done.size() > 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("run_completes_in_time", exp_done.size(), 0);
    @(negedge clk);
    chk("idle_after_done", ap_idle, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset    = 1'b1;
    ap_start = 1'b0;
    num_iter = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_ready", ap_ready, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_write", tok_write, 0);
    chk("rst_din", tok_din, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err_underflow, 0);

    // 1: five iterations, completion 3 cycles after each write
    start_run(5);
    wait_run_end(300);

    // 2: completions withheld -> cap at MAX_INFLIGHT, one release -> one write
    tail_budget = 0;
    start_run(10);
    repeat (12) @(negedge clk);
    chk("t2_writes_capped", run_wr, MAXI);
    chk("t2_inflight_capped", inflight, MAXI);
    tail_budget = 1;
    repeat (12) @(negedge clk);
    chk("t2_one_more_write", run_wr, MAXI + 1);
    tail_budget = -1;
    wait_run_end(500);

    // 3: FIFO full toggling every cycle
    full_mode = 1;
    tail_min  = 1;
    tail_max  = 4;
    start_run(10);
    wait_run_end(500);
    full_mode = 0;

    // 4: empty run
    start_run(0);
    wait_run_end(50);

    // 5: simultaneous write/completion at inflight 2, then underflow in IDLE
    tail_min  = 2;
    tail_max  = 2;
    coincide2 = 0;
    start_run(8);
    wait_run_end(300);
    chk("t5_coincide_at_2", coincide2 > 0, 1);
    force_tail = 1;
    repeat (4) @(negedge clk);
    chk("t5_err_set", err_underflow, 1);
    tail_min = 1;
    tail_max = 5;
    start_run(3);
    wait_run_end(300);
    chk("t5_err_sticky", err_underflow, 1);

    // 6: reset mid-run after 3 of 8 tokens
    tail_min = 3;
    tail_max = 3;
    start_run(8);
    t = 0;
    while (run_wr < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t6_three_written", run_wr, 3);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_idle_after_reset", ap_idle, 1);
    chk("t6_inflight_after_reset", inflight, 0);
    chk("t6_no_done_after_reset", ap_done, 0);
    chk("t6_err_cleared", err_underflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_after_release", ap_idle, 1);
    start_run(2);
    wait_run_end(200);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      full_mode = $urandom_range(0, 2);
      tail_min  = 1;
      tail_max  = $urandom_range(1, 8);
      start_run($urandom_range(0, 12));
      wait_run_end(2000);
    end
    full_mode = 0;

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_kernel_bc_write_back_start_ctrl
